// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: ALU opcodes, MDU op codes, FSM states.
package mdu_seq_pkg;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_NOR = 4'h7;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Shift-add multiply / restoring divide sequencer borrowing the shared ALU one op per granted cycle.
// 33 cycles to done for unsigned ops, +1 per NEG/FIX state; each denied ALU request stalls one cycle.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c
);

  mdu_state_e  state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        z_q, z_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        acc_div, acc_sgn, acc_sa, acc_sb;
  logic [31:0] div_s;
  logic        div_bit, mul_c, fix_lo, fix_hi;

  assign acc_div = (op == MDU_DIVU) || (op == MDU_DIV);
  assign acc_sgn = (op == MDU_MULT) || (op == MDU_DIV);
  assign acc_sa  = acc_sgn & rs_val[31];
  assign acc_sb  = acc_sgn & rt_val[31];

  assign busy = state_q inside {ST_NEG_A, ST_NEG_B, ST_ITER, ST_FIX_LO, ST_FIX_HI};
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    z_d      = z_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    alu_req  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = ALU_NOP;
    // Divide step: 33-bit partial remainder is {m, s}; m set means it already exceeds any divisor.
    div_s    = {hi_q[30:0], lo_q[31]};
    div_bit  = hi_q[31] | (div_s >= b_q);
    mul_c    = (alu_c < hi_q);
    fix_lo   = sa_q ^ sb_q;
    fix_hi   = is_div_q ? sa_q : (sa_q ^ sb_q);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          is_div_d = acc_div;
          sa_d     = acc_sa;
          sb_d     = acc_sb;
          z_d      = 1'b0;
          a_d      = rs_val;
          b_d      = rt_val;
          cnt_d    = '0;
          if (acc_div && (rt_val == '0)) begin
            hi_d    = rs_val;
            lo_d    = DIV_ZERO_LO;
            state_d = ST_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = acc_div ? rs_val : rt_val;
            state_d = acc_sa ? ST_NEG_A : (acc_sb ? ST_NEG_B : ST_ITER);
          end
        end
      end
      ST_NEG_A: begin
        alu_req = 1'b1;
        alu_b   = a_q;
        alu_op  = ALU_SUB;
        if (alu_gnt) begin
          a_d     = alu_c;
          lo_d    = is_div_q ? alu_c : lo_q;
          state_d = sb_q ? ST_NEG_B : ST_ITER;
        end
      end
      ST_NEG_B: begin
        alu_req = 1'b1;
        alu_b   = b_q;
        alu_op  = ALU_SUB;
        if (alu_gnt) begin
          b_d     = alu_c;
          lo_d    = is_div_q ? lo_q : alu_c;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        alu_req = 1'b1;
        if (is_div_q) begin
          alu_a  = div_s;
          alu_b  = b_q;
          alu_op = ALU_SUB;
        end else begin
          alu_a  = hi_q;
          alu_b  = lo_q[0] ? a_q : '0;
          alu_op = ALU_ADD;
        end
        if (alu_gnt) begin
          if (is_div_q) begin
            hi_d = div_bit ? alu_c : div_s;
            lo_d = {lo_q[30:0], div_bit};
          end else begin
            hi_d = {mul_c, alu_c[31:1]};
            lo_d = {alu_c[0], lo_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = fix_lo ? ST_FIX_LO : (fix_hi ? ST_FIX_HI : ST_DONE);
          end
        end
      end
      ST_FIX_LO: begin
        alu_req = 1'b1;
        alu_b   = lo_q;
        alu_op  = ALU_SUB;
        if (alu_gnt) begin
          z_d     = (lo_q == '0);
          lo_d    = alu_c;
          state_d = fix_hi ? ST_FIX_HI : ST_DONE;
        end
      end
      ST_FIX_HI: begin
        alu_req = 1'b1;
        // 64-bit negate: the borrow out of the low word only propagates when it was zero.
        if (!is_div_q && !z_q) begin
          alu_a  = hi_q;
          alu_op = ALU_NOR;
        end else begin
          alu_b  = hi_q;
          alu_op = ALU_SUB;
        end
        if (alu_gnt) begin
          hi_d    = alu_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      z_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      z_q      <= z_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed and random ops against a 64-bit arithmetic reference, with grant patterns.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam logic [31:0] DZ_LO = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, start, alu_gnt;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo, alu_a, alu_b, alu_c;
  logic        busy, done, alu_req;
  logic [3:0]  alu_op;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          pat [256];
  logic [31:0] last_hi, last_lo;
  bit          last_nor;

  mdu_seq #(.DIV_ZERO_LO(DZ_LO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // Shared pipeline ALU stand-in.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_c = alu_a + alu_b;
      ALU_SUB: alu_c = alu_a - alu_b;
      ALU_NOR: alu_c = ~(alu_a | alu_b);
      default: alu_c = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Runs one op from the current cycle (IDLE or DONE); returns in the done cycle.
  // gmode: 0 full grant, 1 alternating 1/0, 2 random.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int gmode, input int poke, input string tag);
    logic signed [63:0] sa64, sb64, r64;
    logic [31:0] ehi, elo;
    bit is_div, sgn, sa_m, sb_m, dz, req_seen;
    int n_gnt, exp_c, got_c, denied, ones;

    is_div = o[1];
    sgn    = o[0];
    sa_m   = sgn & a[31];
    sb_m   = sgn & b[31];
    sa64   = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    sb64   = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    dz     = is_div && (b == 32'h0);
    if (dz) begin
      ehi = a; elo = DZ_LO; n_gnt = 0;
    end else if (is_div) begin
      r64 = sa64 / sb64; elo = r64[31:0];
      r64 = sa64 % sb64; ehi = r64[31:0];
      n_gnt = 32 + int'(sa_m) + int'(sb_m) + int'(sa_m ^ sb_m) + int'(sa_m);
    end else begin
      r64 = sa64 * sb64; {ehi, elo} = r64;
      n_gnt = 32 + int'(sa_m) + int'(sb_m) + 2 * int'(sa_m ^ sb_m);
    end

    for (int i = 0; i < 256; i++) begin
      case (gmode)
        1:       pat[i] = (i % 2 == 0);
        2:       pat[i] = ($urandom_range(0, 3) != 0);
        default: pat[i] = 1'b1;
      endcase
      if (i >= 200) pat[i] = 1'b1;
    end
    exp_c = 1;
    ones  = 0;
    if (n_gnt > 0) begin
      for (int i = 0; i < 256; i++) begin
        if (pat[i]) ones++;
        if (ones == n_gnt) begin exp_c = i + 2; break; end
      end
    end

    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    got_c = 0; denied = 0; req_seen = 1'b0; last_nor = 1'b0;
    for (int c = 1; c <= 250; c++) begin
      alu_gnt = pat[c-1];
      if (c == poke) begin
        start = 1'b1; op = ~o; rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin got_c = c; break; end
      if (alu_req) begin
        req_seen = 1'b1;
        if (!alu_gnt) denied++;
        if (alu_op == ALU_NOR) last_nor = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(got_c), 64'(exp_c));
    check({tag, ".busy_at_done"}, 64'(busy), 64'h0);
    check({tag, ".hi"}, 64'(hi), 64'(ehi));
    check({tag, ".lo"}, 64'(lo), 64'(elo));
    check({tag, ".req_seen"}, 64'(req_seen), 64'(!dz));
    check({tag, ".denied"}, 64'(denied), 64'(exp_c - 1 - n_gnt));
    last_hi = ehi;
    last_lo = elo;
  endtask

  task automatic idle_cycle(input string tag);
    alu_gnt = 1'b1;
    @(posedge clk); #1;
    check({tag, ".idle_busy"}, 64'(busy), 64'h0);
    check({tag, ".idle_done"}, 64'(done), 64'h0);
    check({tag, ".idle_req"}, 64'(alu_req), 64'h0);
    check({tag, ".idle_alu"}, {28'h0, alu_op, alu_a}, {28'h0, ALU_NOP, 32'h0});
    check({tag, ".idle_alu_b"}, 64'(alu_b), 64'h0);
    check({tag, ".hold"}, {hi, lo}, {last_hi, last_lo});
  endtask

  initial begin
    bit done_seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy_done", {busy, done, alu_req}, 64'h0);
    check("reset.hilo", {hi, lo}, 64'h0);
    check("reset.alu", {28'h0, alu_op, alu_a}, {28'h0, ALU_NOP, 32'h0});
    rst = 1'b0;
    last_hi = '0; last_lo = '0;
    idle_cycle("reset");

    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    idle_cycle("multu_max");
    do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_m3x5");
    check("mult_m3x5.nor_used", 64'(last_nor), 64'h1);
    idle_cycle("mult_m3x5");
    do_op(MDU_MULT, 32'hFFFF_FFFC, 32'hC000_0000, 0, 0, "mult_negneg");
    idle_cycle("mult_negneg");
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7d2");
    idle_cycle("div_m7d2");
    do_op(MDU_DIVU, 32'd100, 32'd7, 1, 0, "divu_toggle");
    idle_cycle("divu_toggle");
    do_op(MDU_DIVU, 32'h0000_1234, 32'h0, 0, 0, "divu_zero");
    idle_cycle("divu_zero");
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    idle_cycle("div_ovf");
    do_op(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 10, "start_mid_iter");
    idle_cycle("start_mid_iter");
    do_op(MDU_DIVU, 32'd1000, 32'd33, 2, 0, "b2b_first");
    do_op(MDU_MULT, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, "b2b_second");
    idle_cycle("b2b");

    // Abort by reset mid-iteration.
    start = 1'b1; op = MDU_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid.busy_before", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    check("rst_mid.outputs", {busy, done, alu_req}, 64'h0);
    check("rst_mid.hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    check("rst_mid.no_done", 64'(done_seen), 64'h0);
    last_hi = '0; last_lo = '0;
    idle_cycle("rst_mid");

    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rnd_val();
      rb = rnd_val();
      do_op(ro, ra, rb, $urandom_range(0, 2), 0, $sformatf("rand%0d", t));
      if ($urandom_range(0, 3) != 0) idle_cycle($sformatf("rand%0d", t));
    end
    idle_cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
